// File: rtl/sid_wave_table_arb.sv
// Round-robin arbiter sharing one SID combined-waveform ROM among the voice generators.
// Each grant carries a tag through the ROM latency so the returned byte reaches the right voice.
module sid_wave_table_arb #(
   parameter int VOICES  = 3,
   parameter int AW      = 12,
   parameter int DW      = 8,
   parameter int ROM_LAT = 1
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic [VOICES-1:0]    req,
   input  logic [VOICES*AW-1:0] addr,
   input  logic [VOICES*2-1:0]  sel,
   output logic [VOICES-1:0]    ack,
   output logic [VOICES*DW-1:0] data,
   output logic                 rom_en,
   output logic [AW-1:0]        rom_addr,
   output logic [1:0]           rom_sel,
   input  logic [DW-1:0]        rom_data,
   output logic                 busy
);
   localparam int IDW   = $clog2(VOICES);
   localparam int DEPTH = ROM_LAT + 1;

   logic [IDW-1:0]    ptr_r;
   logic [VOICES-1:0] pending_r;
   logic [DEPTH-1:0]  tag_valid_r;
   logic [IDW-1:0]    tag_id_r [DEPTH];

   logic [AW-1:0]     addr_a_s [VOICES];
   logic [1:0]        sel_a_s  [VOICES];
   logic [VOICES-1:0] eligible_s;
   logic [VOICES-1:0] grant_mask_s;
   logic [VOICES-1:0] ret_mask_s;
   logic [VOICES-1:0] pending_next_s;
   logic              grant_s;
   logic [IDW-1:0]    win_s;
   logic [IDW:0]      cand_s;
   logic              ret_valid_s;
   logic [IDW-1:0]    ret_id_s;

   for (genvar v = 0; v < VOICES; v++) begin : g_unpack
      assign addr_a_s[v] = addr[v*AW +: AW];
      assign sel_a_s[v]  = sel[v*2 +: 2];
   end

   // Round-robin search over eligible voices, starting just after the last winner.
   always_comb begin
      eligible_s = req & ~pending_r;
      grant_s    = 1'b0;
      win_s      = ptr_r;
      cand_s     = '0;
      for (int i = 1; i <= VOICES; i++) begin
         cand_s = {1'b0, ptr_r} + (IDW+1)'(i);
         if (cand_s >= (IDW+1)'(VOICES)) begin
            cand_s = cand_s - (IDW+1)'(VOICES);
         end else begin
            cand_s = cand_s;
         end
         if (!grant_s && eligible_s[cand_s[IDW-1:0]]) begin
            grant_s = 1'b1;
            win_s   = cand_s[IDW-1:0];
         end else begin
            grant_s = grant_s;
         end
      end
   end

   // One-hot grant and return masks; pending clears on return and sets on grant.
   always_comb begin
      ret_valid_s  = tag_valid_r[DEPTH-1];
      ret_id_s     = tag_id_r[DEPTH-1];
      grant_mask_s = '0;
      ret_mask_s   = '0;
      if (grant_s) begin
         grant_mask_s[win_s] = 1'b1;
      end else begin
         grant_mask_s = '0;
      end
      if (ret_valid_s) begin
         ret_mask_s[ret_id_s] = 1'b1;
      end else begin
         ret_mask_s = '0;
      end
      pending_next_s = (pending_r & ~ret_mask_s) | grant_mask_s;
   end

   // Arbitration state, registered ROM request, tag pipeline and per-voice results.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         ptr_r       <= IDW'(VOICES-1);
         pending_r   <= '0;
         tag_valid_r <= '0;
         for (int d = 0; d < DEPTH; d++) begin
            tag_id_r[d] <= '0;
         end
         rom_en      <= 1'b0;
         rom_addr    <= '0;
         rom_sel     <= 2'b00;
         ack         <= '0;
         data        <= '0;
         busy        <= 1'b0;
      end else begin
         rom_en <= grant_s;
         if (grant_s) begin
            rom_addr <= addr_a_s[win_s];
            rom_sel  <= sel_a_s[win_s];
            ptr_r    <= win_s;
         end
         tag_valid_r <= {tag_valid_r[DEPTH-2:0], grant_s};
         tag_id_r[0] <= win_s;
         for (int d = 1; d < DEPTH; d++) begin
            tag_id_r[d] <= tag_id_r[d-1];
         end
         pending_r <= pending_next_s;
         busy      <= |pending_next_s;
         ack       <= ret_mask_s;
         for (int v = 0; v < VOICES; v++) begin
            if (ret_mask_s[v]) begin
               data[v*DW +: DW] <= rom_data;
            end
         end
      end
   end
endmodule

// File: tb/tb_sid_wave_table_arb.sv
// Scoreboard bench for sid_wave_table_arb: stimulus queues expected grants, monitors
// check grants and acks as the DUT presents them, against a behavioural ROM.
module tb_sid_wave_table_arb;
   localparam int VOICES  = 3;
   localparam int AW      = 12;
   localparam int DW      = 8;
   localparam int ROM_LAT = 1;

   logic                 clock = 1'b0;
   logic                 reset_n;
   logic [VOICES-1:0]    req;
   logic [VOICES*AW-1:0] addr;
   logic [VOICES*2-1:0]  sel;
   logic [VOICES-1:0]    ack;
   logic [VOICES*DW-1:0] data;
   logic                 rom_en;
   logic [AW-1:0]        rom_addr;
   logic [1:0]           rom_sel;
   logic [DW-1:0]        rom_data = 8'h00;
   logic                 busy;

   int vectors = 0;
   int errors  = 0;
   int cyc     = 0;

   typedef struct {int id; logic [11:0] a; logic [1:0] s; logic [7:0] d; int c;} gexp_t;
   typedef struct {int id; logic [7:0] d; int c;} aexp_t;
   gexp_t      gq[$];
   aexp_t      aq[$];
   gexp_t      g_m;
   aexp_t      a_m;
   logic [7:0] exp_data [VOICES];

   sid_wave_table_arb #(.VOICES(VOICES), .AW(AW), .DW(DW), .ROM_LAT(ROM_LAT)) dut (
      .clock(clock), .reset_n(reset_n), .req(req), .addr(addr), .sel(sel),
      .ack(ack), .data(data), .rom_en(rom_en), .rom_addr(rom_addr),
      .rom_sel(rom_sel), .rom_data(rom_data), .busy(busy)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   // Stand-in combined-waveform table; ps_ entries chosen to match the hand-worked vectors.
   function automatic logic [7:0] rom_model(input logic [11:0] a, input logic [1:0] s);
      if (s == 2'd0) return (a == 12'h07F) ? 8'h03 : a[11:4];
      else return a[7:0] ^ {s, 6'b000000};
   endfunction

   // Registered ROM, one cycle of latency.
   always @(posedge clock) rom_data <= rom_model(rom_addr, rom_sel);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      vectors++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp_v, cyc);
      end
   endtask

   // Grant monitor: every rom_en must match the next queued grant.
   always @(negedge clock) begin
      if (rom_en === 1'b1) begin
         if (gq.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL unexpected_grant: rom_addr %0h at cycle %0d, required no grant", rom_addr, cyc);
         end else begin
            g_m = gq.pop_front();
            check("grant_addr", 64'(rom_addr), 64'(g_m.a));
            check("grant_sel", 64'(rom_sel), 64'(g_m.s));
            if (g_m.c >= 0) check("grant_cycle", 64'(cyc), 64'(g_m.c));
            aq.push_back('{g_m.id, g_m.d, cyc + ROM_LAT + 1});
         end
      end
      if (ack !== 3'b000) begin
         if (aq.size() == 0) begin
            vectors++;
            errors++;
            $display("FAIL unexpected_ack: ack %b at cycle %0d, required 000", ack, cyc);
         end else begin
            a_m = aq.pop_front();
            check("ack_vector", 64'(ack), 64'(3'b001 << a_m.id));
            check("ack_data", 64'(data[a_m.id*DW +: DW]), 64'(a_m.d));
            check("ack_cycle", 64'(cyc), 64'(a_m.c));
            exp_data[a_m.id] = a_m.d;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      gq.delete();
      aq.delete();
      for (int v = 0; v < VOICES; v++) exp_data[v] = 8'h00;
      @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic drain(input int budget);
      int k = 0;
      while ((gq.size() != 0 || aq.size() != 0) && k < budget) begin
         @(posedge clock);
         k++;
      end
      vectors++;
      if (gq.size() != 0 || aq.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: %0d grants and %0d acks outstanding, required 0", gq.size(), aq.size());
         gq.delete();
         aq.delete();
      end
      step(3);
   endtask

   task automatic check_data(input string name);
      for (int v = 0; v < VOICES; v++) check(name, 64'(data[v*DW +: DW]), 64'(exp_data[v]));
      check({name, "_busy"}, 64'(busy), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0;
      req     = '0;
      addr    = '0;
      sel     = '0;
      for (int v = 0; v < VOICES; v++) exp_data[v] = 8'h00;

      // 1: outputs stay zero under reset with random inputs; idle after release
      for (int i = 0; i < 4; i++) begin
         @(posedge clock);
         #1;
         req  = 3'($urandom);
         addr = 36'({$urandom(), $urandom()});
         sel  = 6'($urandom);
         @(negedge clock);
         check("reset_outputs", 64'({ack, data, rom_en, rom_addr, rom_sel, busy}), 64'd0);
      end
      @(posedge clock);
      #1;
      req     = '0;
      reset_n = 1'b1;
      step(5);
      check("idle_rom_en", 64'(rom_en), 64'd0);
      check_data("idle_data");

      // 2: single lookup from voice 0
      addr = {12'h000, 12'h000, 12'h07F};
      sel  = 6'b000000;
      gq.push_back('{0, 12'h07F, 2'd0, 8'h03, cyc + 1});
      req = 3'b001;
      step(1);
      req = 3'b000;
      drain(20);
      check_data("single_data");

      // 3: all voices at once after reset, granted in index order
      pulse_reset();
      addr = {12'hFFF, 12'h3FF, 12'h07F};
      sel  = 6'b000000;
      gq.push_back('{0, 12'h07F, 2'd0, 8'h03, cyc + 1});
      gq.push_back('{1, 12'h3FF, 2'd0, 8'h3F, cyc + 2});
      gq.push_back('{2, 12'hFFF, 2'd0, 8'hFF, cyc + 3});
      req = 3'b111;
      step(3);
      req = 3'b000;
      drain(20);
      check_data("all_data");

      // 4: voices 0 and 2 hold req for 40 cycles and must alternate
      addr = {12'h456, 12'h000, 12'h123};
      sel  = {2'd3, 2'd0, 2'd1};
      for (int i = 0; i < 14; i++) begin
         gq.push_back('{0, 12'h123, 2'd1, 8'h63, cyc + 1 + 3*i});
         if (i < 13) gq.push_back('{2, 12'h456, 2'd3, 8'h96, cyc + 2 + 3*i});
      end
      req = 3'b101;
      step(40);
      req = 3'b000;
      drain(20);
      check_data("hold_data");

      // 5: reset while voice 1 is in flight discards its return
      addr = {12'h000, 12'h200, 12'h000};
      sel  = {2'd0, 2'd2, 2'd0};
      gq.push_back('{1, 12'h200, 2'd2, 8'h80, cyc + 1});
      req = 3'b010;
      step(1);
      req = 3'b000;
      @(negedge clock);
      #1;
      pulse_reset();
      step(6);
      check("reset_gq_empty", 64'(gq.size()), 64'd0);
      check_data("midreset_data");
      addr = {12'h000, 12'h210, 12'h000};
      gq.push_back('{1, 12'h210, 2'd2, 8'h90, cyc + 1});
      req = 3'b010;
      step(1);
      req = 3'b000;
      drain(20);
      check_data("after_reset_data");

      // 6: voice 2 drops req while pending; result still returns
      addr = {12'h0AB, 12'h000, 12'h000};
      sel  = {2'd1, 2'd0, 2'd0};
      gq.push_back('{2, 12'h0AB, 2'd1, 8'hEB, cyc + 1});
      req = 3'b100;
      step(1);
      req = 3'b000;
      drain(20);
      step(6);
      check_data("drop_data");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
